sync_fifo_fwft: RTL and testbench

- Single-clock, parametrised successor to the team's dual-clock sample FIFO.
- Buffers samples between same-clock producer and consumer stages, e.g. ramp/ADC capture to the FFT front-end once both run on the system clock.
- Adds selectable first-word-fall-through (FWFT) read mode, occupancy count, programmable almost-full/almost-empty thresholds and synchronous flush.
- Adds sticky overflow/underflow error flags in place of simulation-only fatal checks.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_ram_1w1r.sv | 35 +++
 rtl/sync_fifo_fwft.sv | 160 ++++++++++++++++
 tb/tb_sync_fifo_fwft.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and parameter helpers, used by the single-clock FIFO
// and the dual-clock sample FIFO.
package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   // Occupancy counters and pointers need one bit above the address to reach DEPTH.
   function automatic int level_width(input int addr_width);
      return addr_width + 1;
   endfunction

   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   function automatic bit thresh_ok(input int addr_width, input int afull, input int aempty);
      int depth;
      depth = 1 << addr_width;
      return (addr_width >= 1) && (afull >= 1) && (afull <= depth) &&
             (aempty >= 0) && (aempty <= depth - 1);
   endfunction

   function automatic bit mode_ok(input int mode);
      return (mode == FIFO_MODE_STD) || (mode == FIFO_MODE_FWFT);
   endfunction

endpackage

// File: rtl/fifo_ram_1w1r.sv
// Flop-based storage, one synchronous write port and one asynchronous read port.
module fifo_ram_1w1r
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Storage carries no reset: contents are only observable through valid pointers.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read,
// occupancy and threshold flags, synchronous flush and sticky error flags.
module sync_fifo_fwft
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDR_WIDTH    = 4,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);
   localparam int LW    = level_width(ADDR_WIDTH);

   localparam logic [LW-1:0] DEPTH_LVL  = LW'(DEPTH);
   localparam logic [LW-1:0] AFULL_LVL  = LW'(AFULL_THRESH);
   localparam logic [LW-1:0] AEMPTY_LVL = LW'(AEMPTY_THRESH);

   if (!thresh_ok(ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
      $error("sync_fifo_fwft: ADDR_WIDTH or almost-full/almost-empty threshold out of range");
   end

   if (!mode_ok(FWFT)) begin : g_bad_mode
      $error("sync_fifo_fwft: FWFT must be FIFO_MODE_STD or FIFO_MODE_FWFT");
   end

   logic [LW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q,  level_d;
   logic          overflow_q,  overflow_d;
   logic          underflow_q, underflow_d;

   logic                  full_s, empty_s;
   logic                  wr_acc, rd_acc;
   logic                  ovf_set, unf_set;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Handshake: a write is taken on an edge where wr_en=1, full=0 and flush=0; a read
   // (or FWFT pop) on an edge where rd_en=1, empty=0 and flush=0. Requests outside
   // those conditions are dropped and, unless flushing, raise overflow/underflow.
   assign full_s  = (level_q == DEPTH_LVL);
   assign empty_s = (level_q == '0);

   assign wr_acc = wr_en & ~full_s & ~flush;
   assign rd_acc = rd_en & ~empty_s & ~flush;

   assign ovf_set = wr_en & full_s & ~flush;
   assign unf_set = rd_en & empty_s & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + LW'(1);
         end
         if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + LW'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // A violation in the same cycle as clr_err keeps its flag set.
   always_comb begin
      overflow_d  = ovf_set | (overflow_q  & ~clr_err);
      underflow_d = unf_set | (underflow_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_ram_1w1r #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd_data (ram_rdata)
   );

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is presented straight from storage; rd_en only advances the pointer.
      assign rd_data  = ram_rdata;
      assign rd_valid = ~empty_s;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
         rd_valid_d = rd_acc;
         rd_data_d  = rd_acc ? ram_rdata : rd_data_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
         end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
   end

   assign full         = full_s;
   assign empty        = empty_s;
   assign almost_full  = (level_q >= AFULL_LVL);
   assign almost_empty = (level_q <= AEMPTY_LVL);
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: standard and FWFT instances share stimulus and are
// checked every cycle against a queue model plus directed literal expectations.
module tb_sync_fifo_fwft;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [15:0] wr_data;
   logic        wr_en;
   logic        rd_en;
   logic        clr_err;

   logic        s_full, s_afull, s_rd_valid, s_empty, s_aempty, s_ovf, s_unf;
   logic [15:0] s_rd_data;
   logic [4:0]  s_level;
   logic        f_full, f_afull, f_rd_valid, f_empty, f_aempty, f_ovf, f_unf;
   logic [15:0] f_rd_data;
   logic [4:0]  f_level;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 0;

   logic [15:0] exp_q[$];
   bit          m_ovf, m_unf, m_std_valid;
   logic [15:0] m_std_data;

   sync_fifo_fwft #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(0), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_std (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
      .full(s_full), .almost_full(s_afull), .rd_en(rd_en), .rd_data(s_rd_data),
      .rd_valid(s_rd_valid), .empty(s_empty), .almost_empty(s_aempty), .level(s_level),
      .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
   );

   sync_fifo_fwft #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_fwft (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
      .full(f_full), .almost_full(f_afull), .rd_en(rd_en), .rd_data(f_rd_data),
      .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_aempty), .level(f_level),
      .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   task automatic model_step();
      bit was_full, was_empty;
      was_full  = (exp_q.size() == 16);
      was_empty = (exp_q.size() == 0);
      if (clr_err) begin
         m_ovf = 0;
         m_unf = 0;
      end
      if (flush) begin
         exp_q.delete();
         m_std_valid = 0;
      end else begin
         if (wr_en && was_full)  m_ovf = 1;
         if (rd_en && was_empty) m_unf = 1;
         if (rd_en && !was_empty) begin
            m_std_data  = exp_q.pop_front();
            m_std_valid = 1;
         end else begin
            m_std_valid = 0;
         end
         if (wr_en && !was_full) exp_q.push_back(wr_data);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            exp_q.delete();
            m_ovf       = 0;
            m_unf       = 0;
            m_std_valid = 0;
            m_std_data  = '0;
         end else begin
            model_step();
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   task automatic compare_all();
      int n;
      n = exp_q.size();
      chk("std_level",  32'(s_level),  32'(n));
      chk("fwft_level", 32'(f_level),  32'(n));
      chk("std_empty",  32'(s_empty),  32'(n == 0));
      chk("fwft_empty", 32'(f_empty),  32'(n == 0));
      chk("std_full",   32'(s_full),   32'(n == 16));
      chk("fwft_full",  32'(f_full),   32'(n == 16));
      chk("std_afull",  32'(s_afull),  32'(n >= 12));
      chk("fwft_afull", 32'(f_afull),  32'(n >= 12));
      chk("std_aempty", 32'(s_aempty), 32'(n <= 2));
      chk("fwft_aempty",32'(f_aempty), 32'(n <= 2));
      chk("std_ovf",    32'(s_ovf),    32'(m_ovf));
      chk("fwft_ovf",   32'(f_ovf),    32'(m_ovf));
      chk("std_unf",    32'(s_unf),    32'(m_unf));
      chk("fwft_unf",   32'(f_unf),    32'(m_unf));
      chk("std_rd_valid",  32'(s_rd_valid), 32'(m_std_valid));
      chk("std_rd_data",   32'(s_rd_data),  32'(m_std_data));
      chk("fwft_rd_valid", 32'(f_rd_valid), 32'(n != 0));
      if (n != 0) chk("fwft_rd_data", 32'(f_rd_data), 32'(exp_q[0]));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) compare_all();
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle(input bit wr, input logic [15:0] wd, input bit rd, input bit fl, input bit clr);
      wr_en   = wr;
      wr_data = wd;
      rd_en   = rd;
      flush   = fl;
      clr_err = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(0, 16'h0, 0, 0, 0);
   endtask

   task automatic wr_word(input logic [15:0] d);
      cycle(1, d, 0, 0, 0);
   endtask

   task automatic rd_word();
      cycle(0, 16'h0, 1, 0, 0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst_n = 1'b1; flush = 0; wr_data = '0; wr_en = 0; rd_en = 0; clr_err = 0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_level", 32'(s_level), 0);
      chk("rst_empty", 32'(s_empty), 1);
      chk("rst_aempty", 32'(s_aempty), 1);
      chk("rst_full", 32'(s_full), 0);
      chk("rst_afull", 32'(s_afull), 0);
      chk("rst_rd_valid", 32'(s_rd_valid), 0);
      chk("rst_rd_data", 32'(s_rd_data), 0);
      chk("rst_fwft_valid", 32'(f_rd_valid), 0);
      chk("rst_ovf", 32'(s_ovf), 0);
      chk("rst_unf", 32'(s_unf), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n  = 1'b1;
      chk_en = 1;

      // Fill 0x0000..0x000F, then overflow with 0xBEEF
      for (int i = 0; i < 16; i++) begin
         wr_word(16'(i));
         if (i == 0)  chk("fwft_first_word", 32'(f_rd_data), 0);
         if (i == 1)  chk("fill_aempty_at2", 32'(s_aempty), 1);
         if (i == 2)  chk("fill_aempty_at3", 32'(s_aempty), 0);
         if (i == 10) chk("fill_afull_at11", 32'(s_afull), 0);
         if (i == 11) chk("fill_afull_at12", 32'(s_afull), 1);
      end
      chk("fill_full", 32'(s_full), 1);
      chk("fill_level16", 32'(s_level), 16);
      wr_word(16'hBEEF);
      chk("ovf_set", 32'(s_ovf), 1);
      chk("ovf_level", 32'(s_level), 16);

      // Drain: each read returns the next word with rd_valid the following cycle
      for (int i = 0; i < 16; i++) begin
         rd_word();
         chk("drain_valid", 32'(s_rd_valid), 1);
         chk("drain_data", 32'(s_rd_data), 32'(i));
      end
      idle();
      chk("drain_empty", 32'(s_empty), 1);
      chk("drain_valid_low", 32'(s_rd_valid), 0);
      chk("drain_hold_data", 32'(s_rd_data), 'hF);

      // Underflow, clear, set-wins-over-clear
      rd_word();
      chk("unf_set", 32'(s_unf), 1);
      chk("unf_no_valid", 32'(s_rd_valid), 0);
      cycle(0, 16'h0, 0, 0, 1);
      chk("clr_ovf", 32'(s_ovf), 0);
      chk("clr_unf", 32'(s_unf), 0);
      cycle(0, 16'h0, 1, 0, 1);
      chk("set_wins_unf", 32'(s_unf), 1);
      cycle(0, 16'h0, 0, 0, 1);

      // Write+read at level 0: write taken, read rejected
      cycle(1, 16'hA5A5, 1, 0, 0);
      chk("lvl0_wr_rd_level", 32'(s_level), 1);
      chk("lvl0_wr_rd_unf", 32'(s_unf), 1);
      chk("lvl0_wr_rd_novalid", 32'(s_rd_valid), 0);
      cycle(0, 16'h0, 0, 0, 1);
      rd_word();
      chk("lvl0_word_out", 32'(s_rd_data), 'hA5A5);

      // Simultaneous traffic at level 5
      for (int i = 0; i < 5; i++) wr_word(16'(16'h0100 + i));
      for (int i = 0; i < 10; i++) begin
         cycle(1, 16'(16'h0200 + i), 1, 0, 0);
         chk("lvl5_level", 32'(s_level), 5);
         if (i == 0) chk("lvl5_first", 32'(s_rd_data), 'h0100);
         if (i == 5) chk("lvl5_sixth", 32'(s_rd_data), 'h0200);
      end
      for (int i = 0; i < 5; i++) rd_word();
      chk("lvl5_last", 32'(s_rd_data), 'h0209);

      // Write+read at level 16: read taken, write rejected
      for (int i = 0; i < 16; i++) wr_word(16'(16'h0300 + i));
      cycle(1, 16'hDEAD, 1, 0, 0);
      chk("lvl16_level", 32'(s_level), 15);
      chk("lvl16_ovf", 32'(s_ovf), 1);
      chk("lvl16_data", 32'(s_rd_data), 'h0300);
      cycle(0, 16'h0, 0, 0, 1);
      for (int i = 0; i < 15; i++) rd_word();
      chk("lvl16_last", 32'(s_rd_data), 'h030F);
      chk("lvl16_empty", 32'(s_empty), 1);

      // FWFT fall-through and pop
      wr_word(16'h1234);
      chk("fwft_valid_1234", 32'(f_rd_valid), 1);
      chk("fwft_data_1234", 32'(f_rd_data), 'h1234);
      wr_word(16'h5678);
      chk("fwft_hold_1234", 32'(f_rd_data), 'h1234);
      rd_word();
      chk("fwft_data_5678", 32'(f_rd_data), 'h5678);
      chk("fwft_valid_5678", 32'(f_rd_valid), 1);
      rd_word();
      chk("fwft_valid_low", 32'(f_rd_valid), 0);

      // Wrap: 40 write/read pairs at level 3
      for (int i = 0; i < 3; i++) wr_word(16'(16'h0400 + i));
      for (int i = 0; i < 40; i++) cycle(1, 16'(16'h0500 + i), 1, 0, 0);
      chk("wrap_level", 32'(s_level), 3);
      for (int i = 0; i < 3; i++) rd_word();
      chk("wrap_last", 32'(s_rd_data), 'h0527);

      // Flush at level 9 with a write and a read pending
      for (int i = 0; i < 9; i++) wr_word(16'(16'h0600 + i));
      cycle(1, 16'hF1F1, 1, 1, 0);
      chk("flush_level", 32'(s_level), 0);
      chk("flush_empty", 32'(s_empty), 1);
      chk("flush_ovf", 32'(s_ovf), 0);
      chk("flush_unf", 32'(s_unf), 0);
      chk("flush_novalid", 32'(s_rd_valid), 0);
      chk("flush_keep_data", 32'(s_rd_data), 'h0527);
      wr_word(16'h0777);
      rd_word();
      chk("post_flush_word", 32'(s_rd_data), 'h0777);

      // Asynchronous reset in the middle of a write burst
      for (int i = 0; i < 6; i++) wr_word(16'(16'h0800 + i));
      wr_en = 1; wr_data = 16'h08FF;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_level", 32'(s_level), 0);
      chk("arst_empty", 32'(s_empty), 1);
      chk("arst_aempty", 32'(s_aempty), 1);
      chk("arst_full", 32'(s_full), 0);
      chk("arst_rd_data", 32'(s_rd_data), 0);
      chk("arst_rd_valid", 32'(s_rd_valid), 0);
      chk("arst_fwft_valid", 32'(f_rd_valid), 0);
      chk("arst_fwft_level", 32'(f_level), 0);
      wr_en = 0; wr_data = '0;
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      chk("arst_after_level", 32'(s_level), 0);
      idle();

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
